// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: PC owner feeding a registered instruction queue to decode.
// Optional FETCH_HALT_ON_ZERO_EN: a fetched 32'h0 word halts fetch until a redirect.
module imem_fetch_sequencer #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_run,
  output logic [PC_W-1:0] out_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_redirect,
  input  logic [PC_W-1:0] in_redirect_pc,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_inst_pc,
  output logic            out_valid,
  input  logic            in_ready,
  output logic            out_halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem [DEPTH];
  logic [31:0] last_inst_q;
  logic [PC_W-1:0] last_pc_q;
  logic fetch, room, zero, push, pop;
  assign out_valid = cnt_q != '0;
  assign pop = out_valid && in_ready && !in_redirect;
  assign fetch = state_q == FETCH && in_run && !in_redirect;
  assign room = cnt_q < CW'(DEPTH) || pop;
`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero = fetch && in_inst == 32'h0;
  assign out_halted = state_q == HALT;
`else
  assign zero = 1'b0;
  assign out_halted = 1'b0;
`endif
  assign push = fetch && room && !zero;
  assign out_pc = pc_q;
  // head is read straight from the queue; the last head is held once it drains
  assign out_inst = out_valid ? inst_mem[rd_q] : last_inst_q;
  assign out_inst_pc = out_valid ? pc_mem[rd_q] : last_pc_q;
  always_comb begin
    state_d = state_q == IDLE ? (in_run ? FETCH : IDLE) :
              state_q == HALT ? (in_redirect ? FETCH : HALT) :
              !in_run ? IDLE : zero ? HALT : FETCH;
    pc_d = in_redirect ? in_redirect_pc : push ? pc_q + PC_W'(1) : pc_q;
    rd_d = in_redirect ? '0 : pop ? rd_q + AW'(1) : rd_q;
    wr_d = in_redirect ? '0 : push ? wr_q + AW'(1) : wr_q;
    cnt_d = in_redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      last_inst_q <= '0;
      last_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      if (out_valid) begin
        last_inst_q <= inst_mem[rd_q];
        last_pc_q <= pc_mem[rd_q];
      end
    end
  end
  always_ff @(posedge in_clk) begin
    if (push) begin
      inst_mem[wr_q] <= in_inst;
      pc_mem[wr_q] <= pc_q;
    end
  end
endmodule
